// File: rtl/key_slot_sequencer.sv
// Key slot store with a dwell-timed sequencer that presents one stored key at a time.
// Modes: hold slot 0, round-robin, alternate slot 0 with a blank phase, one-shot pass.
module key_slot_sequencer #(
  parameter int KEY_W     = 128,
  parameter int NUM_SLOTS = 4,
  parameter int PERIOD_W  = 16,
  localparam int IDX_W    = $clog2(NUM_SLOTS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [KEY_W-1:0]    wr_key,
  input  logic [PERIOD_W-1:0] period,
  input  logic [1:0]          mode,
  input  logic                start,
  input  logic                stop,
  output logic [KEY_W-1:0]    key_out,
  output logic                key_valid,
  output logic [IDX_W-1:0]    slot_idx,
  output logic                busy,
  output logic                wrap
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

  state_t              state, state_n;
  logic [PERIOD_W-1:0] cnt, cnt_n;
  logic [PERIOD_W-1:0] per_q, per_n;
  logic [1:0]          mode_q, mode_n;
  logic                phase, phase_n;
  logic [IDX_W-1:0]    idx_n;
  logic                valid_n;
  logic                wrap_n;
  logic [KEY_W-1:0]    key_n;
  logic [KEY_W-1:0]    slots [NUM_SLOTS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
    end else if (wr_en) begin
      slots[wr_idx] <= wr_key;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      per_q     <= '0;
      mode_q    <= '0;
      phase     <= 1'b0;
      slot_idx  <= '0;
      key_valid <= 1'b0;
      wrap      <= 1'b0;
      key_out   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      per_q     <= per_n;
      mode_q    <= mode_n;
      phase     <= phase_n;
      slot_idx  <= idx_n;
      key_valid <= valid_n;
      wrap      <= wrap_n;
      key_out   <= key_n;
    end
  end

  assign busy = (state == RUN);

  // phase=1 marks the blank half of alternate mode; a dwell step ends when cnt hits zero
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    per_n   = per_q;
    mode_n  = mode_q;
    phase_n = phase;
    idx_n   = slot_idx;
    valid_n = key_valid;
    wrap_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n = RUN;
          per_n   = (period == '0) ? PERIOD_W'(1) : period;
          cnt_n   = per_n - 1'b1;
          mode_n  = mode;
          phase_n = 1'b0;
          idx_n   = '0;
          valid_n = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
          cnt_n   = '0;
          phase_n = 1'b0;
          idx_n   = '0;
          valid_n = 1'b0;
        end else if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          cnt_n = per_q - 1'b1;
          case (mode_q)
            2'd1: begin
              idx_n  = slot_idx + 1'b1;
              wrap_n = (slot_idx == LAST_IDX);
            end
            2'd2: begin
              phase_n = !phase;
              valid_n = phase;
              wrap_n  = phase;
            end
            2'd3: begin
              if (slot_idx == LAST_IDX) begin
                state_n = IDLE;
                cnt_n   = '0;
                idx_n   = '0;
                valid_n = 1'b0;
                wrap_n  = 1'b1;
              end else begin
                idx_n = slot_idx + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A same-edge write to the slot about to be shown is forwarded so key_out never lags the store
  always_comb begin
    key_n = '0;
    if (valid_n) key_n = (wr_en && (wr_idx == idx_n)) ? wr_key : slots[idx_n];
  end

endmodule

// File: tb/tb_key_slot_sequencer.sv
// Self-checking bench for key_slot_sequencer: directed vector table, corner sequences,
// and random traffic compared against a step-count reference model.
module tb_key_slot_sequencer;

  localparam int KEY_W = 128;
  localparam int N     = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [1:0]       wr_idx;
  logic [KEY_W-1:0] wr_key;
  logic [15:0]      period;
  logic [1:0]       mode;
  logic             start;
  logic             stop;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic [1:0]       slot_idx;
  logic             busy;
  logic             wrap;

  int check_count = 0;
  int pass_count  = 0;

  key_slot_sequencer #(.KEY_W(KEY_W), .NUM_SLOTS(N), .PERIOD_W(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .period(period), .mode(mode), .start(start), .stop(stop),
    .key_out(key_out), .key_valid(key_valid), .slot_idx(slot_idx),
    .busy(busy), .wrap(wrap)
  );

  always #5 clk = ~clk;

  localparam logic [KEY_W-1:0] K0 = {16{8'h11}};
  localparam logic [KEY_W-1:0] K1 = {16{8'h22}};
  localparam logic [KEY_W-1:0] K2 = {16{8'h33}};
  localparam logic [KEY_W-1:0] K3 = {16{8'h44}};
  localparam logic [KEY_W-1:0] KA = {16{8'hAA}};

  typedef struct {
    logic             we;
    logic [1:0]       widx;
    logic [KEY_W-1:0] wkey;
    logic [15:0]      per;
    logic [1:0]       md;
    logic             st;
    logic             sp;
    logic [KEY_W-1:0] ekey;
    logic             evalid;
    logic [1:0]       eidx;
    logic             ebusy;
    logic             ewrap;
  } vec_t;

  vec_t vecs[$];

  // Reference model: position in the sequence is derived from cycles elapsed since start
  logic [KEY_W-1:0] m_slots [N];
  bit m_run;
  int m_t;
  int m_eff;
  int m_mode;
  bit m_wrap;

  function automatic vec_t mk(logic we, logic [1:0] widx, logic [KEY_W-1:0] wkey,
                              logic [15:0] per, logic [1:0] md, logic st, logic sp,
                              logic [KEY_W-1:0] ekey, logic evalid, logic [1:0] eidx,
                              logic ebusy, logic ewrap);
    vec_t v;
    v.we = we; v.widx = widx; v.wkey = wkey; v.per = per; v.md = md;
    v.st = st; v.sp = sp; v.ekey = ekey; v.evalid = evalid; v.eidx = eidx;
    v.ebusy = ebusy; v.ewrap = ewrap;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_slots[i] = '0;
    m_run = 0; m_t = 0; m_eff = 1; m_mode = 0; m_wrap = 0;
  endtask

  task automatic model_edge();
    int step;
    if (wr_en) m_slots[wr_idx] = wr_key;
    m_wrap = 0;
    if (m_run) begin
      if (stop) begin
        m_run = 0;
      end else begin
        m_t++;
        step = m_t / m_eff;
        if (m_t % m_eff == 0) begin
          case (m_mode)
            1: m_wrap = (step % N == 0);
            2: m_wrap = (step % 2 == 0);
            3: if (step >= N) begin m_run = 0; m_wrap = 1; end
            default: ;
          endcase
        end
      end
    end else if (start && !stop) begin
      m_run  = 1;
      m_t    = 0;
      m_mode = mode;
      m_eff  = (period == 0) ? 1 : int'(period);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] widx,
                               input logic [KEY_W-1:0] wkey, input logic [15:0] per,
                               input logic [1:0] md, input logic st, input logic sp);
    wr_en = we; wr_idx = widx; wr_key = wkey; period = per; mode = md;
    start = st; stop = sp;
  endtask

  task automatic checkOutput(input string name, input logic [KEY_W-1:0] act,
                             input logic [KEY_W-1:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    int               step;
    int               e_idx;
    bit               e_valid;
    logic [KEY_W-1:0] e_key;
    step    = m_run ? (m_t / m_eff) : 0;
    e_idx   = (m_run && (m_mode == 1 || m_mode == 3)) ? step % N : 0;
    e_valid = m_run && !(m_mode == 2 && step % 2 == 1);
    e_key   = e_valid ? m_slots[e_idx] : '0;
    checkOutput({tag, ".key_out"}, key_out, e_key);
    checkOutput({tag, ".key_valid"}, key_valid, e_valid);
    checkOutput({tag, ".slot_idx"}, slot_idx, e_idx);
    checkOutput({tag, ".busy"}, busy, m_run);
    checkOutput({tag, ".wrap"}, wrap, m_wrap);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, '0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_model("reset");
    rst = 1'b0;

    // Fill, round-robin at dwell 3 through one wrap, stop, then start+stop collision
    vecs.push_back(mk(1, 0, K0, 0, 0, 0, 0, '0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, K1, 0, 0, 0, 0, '0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2, K2, 0, 0, 0, 0, '0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, K3, 0, 0, 0, 0, '0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, '0, 3, 1, 1, 0, K0, 1, 0, 1, 0));
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 3; c++) begin
        if (s == 0 && c == 0) continue;
        vecs.push_back(mk(0, 0, '0, 0, 0, 0, 0,
                          (s == 0) ? K0 : (s == 1) ? K1 : (s == 2) ? K2 : K3,
                          1, 2'(s), 1, 0));
      end
    end
    vecs.push_back(mk(0, 0, '0, 0, 0, 0, 0, K0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, '0, 0, 0, 0, 0, K0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, '0, 0, 0, 0, 1, '0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, '0, 2, 1, 1, 1, '0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, '0, 0, 0, 0, 0, '0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].we, vecs[i].widx, vecs[i].wkey, vecs[i].per,
                    vecs[i].md, vecs[i].st, vecs[i].sp);
      step_cycle();
      checkOutput($sformatf("vec%0d.key_out", i), key_out, vecs[i].ekey);
      checkOutput($sformatf("vec%0d.key_valid", i), key_valid, vecs[i].evalid);
      checkOutput($sformatf("vec%0d.slot_idx", i), slot_idx, vecs[i].eidx);
      checkOutput($sformatf("vec%0d.busy", i), busy, vecs[i].ebusy);
      checkOutput($sformatf("vec%0d.wrap", i), wrap, vecs[i].ewrap);
    end

    // One-shot with period 0: four single-cycle steps then back to idle
    applyStimulus(0, 0, '0, 0, 3, 1, 0);
    step_cycle();
    check_model("oneshot");
    applyStimulus(0, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step_cycle();
      check_model("oneshot");
    end
    checkOutput("oneshot.done_busy", busy, 1'b0);

    // Alternate mode with period 2
    applyStimulus(0, 0, '0, 2, 2, 1, 0);
    step_cycle();
    check_model("alt");
    applyStimulus(0, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step_cycle();
      check_model("alt");
    end
    applyStimulus(0, 0, '0, 0, 0, 0, 1);
    step_cycle();
    check_model("alt_stop");

    // Overwrite slot 1 while it is on display, dwell 4
    applyStimulus(0, 0, '0, 4, 1, 1, 0);
    step_cycle();
    applyStimulus(0, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step_cycle();
      check_model("wrpres");
    end
    applyStimulus(1, 1, KA, 0, 0, 0, 0);
    step_cycle();
    check_model("wrpres");
    checkOutput("wrpres.key_aa", key_out, KA);
    applyStimulus(0, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step_cycle();
      check_model("wrpres");
    end
    checkOutput("wrpres.idx_after_dwell", slot_idx, 2'd3);

    // Asynchronous reset between edges, then start in the first cycle after release
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    checkOutput("arst.key_out", key_out, '0);
    checkOutput("arst.key_valid", key_valid, 1'b0);
    checkOutput("arst.slot_idx", slot_idx, 2'd0);
    checkOutput("arst.busy", busy, 1'b0);
    checkOutput("arst.wrap", wrap, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, '0, 1, 1, 1, 0);
    step_cycle();
    check_model("arst_restart");
    checkOutput("arst.busy_after", busy, 1'b1);
    applyStimulus(0, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step_cycle();
      check_model("arst_restart");
    end

    // Random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
                    {$urandom, $urandom, $urandom, $urandom},
                    16'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0);
      step_cycle();
      check_model("rand");
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/key_slot_sequencer.md
KEY_SLOT_SEQUENCER -- requirements
Module: key_slot_sequencer

Interface
REQ-001 SHALL have parameter KEY_W, default 128, key width in bits.
REQ-002 SHALL have parameter NUM_SLOTS, default 4, number of key slots (power of two, >=2); IDX_W = log2(NUM_SLOTS).
REQ-003 SHALL have parameter PERIOD_W, default 16, dwell-counter width.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 wr_en  input  1  slot write strobe.
REQ-007 wr_idx  input  IDX_W  slot written when wr_en=1.
REQ-008 wr_key  input  KEY_W  key data written.
REQ-009 period  input  PERIOD_W  dwell cycles per slot, sampled on accepted start.
REQ-010 mode  input  2  sequencing mode, sampled on accepted start.
REQ-011 start  input  1  begin sequencing (pulse).
REQ-012 stop  input  1  abort sequencing (pulse).
REQ-013 key_out  output  KEY_W  current presented key, registered.
REQ-014 key_valid  output  1  key_out carries a slot key.
REQ-015 slot_idx  output  IDX_W  slot currently presented.
REQ-016 busy  output  1  high while in RUN.
REQ-017 wrap  output  1  one-cycle pulse when the sequence returns to slot 0 or completes.

Function
REQ-018 SHALL implement FSM states IDLE and RUN; IDLE->RUN on start=1 and stop=0; RUN->IDLE on stop=1 or one-shot completion.
REQ-019 start while in RUN SHALL be ignored; start and stop in the same cycle SHALL be treated as stop only.
REQ-020 On accepted start: slot_idx<=0, dwell counter<=eff_period-1, mode and period latched, busy<=1, key_out<=slot[0], key_valid<=1, all visible the cycle after start.
REQ-021 eff_period SHALL equal period, except period=0 SHALL be treated as 1 (advance every cycle).
REQ-022 In RUN the dwell counter SHALL decrement each cycle; when it is 0 the sequence SHALL advance and the counter reload to eff_period-1, so each step lasts exactly eff_period cycles.
REQ-023 mode 0 (hold): slot_idx stays 0, no advance, no wrap; runs until stop.
REQ-024 mode 1 (round-robin): slot_idx increments modulo NUM_SLOTS; wrap pulses in the cycle slot_idx returns to 0.
REQ-025 mode 2 (alternate): steps alternate between slot 0 with key_valid=1 and an all-zero key_out with key_valid=0; slot_idx stays 0; wrap pulses on each return to the valid phase.
REQ-026 mode 3 (one-shot): as mode 1, but after the last slot's dwell expires the block SHALL return to IDLE, pulse wrap once, and not re-present slot 0.
REQ-027 key_out SHALL always equal the contents of slot[slot_idx] (or zero in the mode-2 invalid phase) one cycle after any change of slot_idx or of that slot's contents.
REQ-028 wr_en SHALL write slot[wr_idx] on the rising edge in any state; a write to the presented slot SHALL appear on key_out the following cycle without disturbing the dwell counter.
REQ-029 In IDLE key_out SHALL be zero, key_valid=0, busy=0, slot_idx=0; slot contents SHALL be retained.
REQ-030 wrap SHALL never be high for more than one consecutive cycle when eff_period>1.

Reset
REQ-031 rst=1 SHALL immediately, without waiting for a clock edge, set state=IDLE, counter=0, all slots=0, key_out=0, key_valid=0, slot_idx=0, busy=0, wrap=0.
REQ-032 Reset asserted mid-RUN SHALL abort the sequence; after release the block SHALL wait for a new start.
REQ-033 start in the first cycle after rst deasserts SHALL be accepted normally.

Verification
REQ-034 Write slots 0..3 = 0x11..,0x22..,0x33..,0x44.., mode=1, period=3, start -> each key held 3 cycles in order 0,1,2,3,0; wrap one pulse at the return to slot 0; busy=1 throughout.
REQ-035 mode=3, period=0, start -> slots 0,1,2,3 for one cycle each, then IDLE with key_out=0, busy=0, single wrap pulse.
REQ-036 mode=2, period=2 -> key_out alternates slot0 (valid=1) 2 cycles / zero (valid=0) 2 cycles; wrap on each return to valid.
REQ-037 start and stop in the same cycle from IDLE -> remains IDLE; stop mid-RUN -> IDLE next cycle, key_out=0.
REQ-038 Write slot 1 = 0xAA.. while slot 1 is presented in mode 1 -> key_out=0xAA.. next cycle, dwell timing unchanged.
REQ-039 Assert rst asynchronously mid-RUN between clock edges -> all outputs zero before the next edge; slots read back zero after a new start.
